// File: rtl/soc_pio_button.sv
// Debounced button input port with edge capture, interrupt mask and an Avalon-MM slave.
// Pins are synchronized, debounced per bit, and debounced edges latch into sticky capture bits.
module soc_pio_button #(
   parameter int                 WIDTH           = 4,
   parameter int                 DEBOUNCE_CYCLES = 50000,
   parameter int                 EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0]   RESET_VALUE     = '1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [WIDTH-1:0]  in_port,
   output logic [31:0]       readdata,
   output logic              irq
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] deb_q, deb_d;
   logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic             irq_q, irq_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   logic             wr_en;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clr_mask;
   logic [31:0]      rdata;

   assign wr_en = chipselect & ~write_n;

   always_comb begin
      sync1_d   = in_port;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_dly_d = deb_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         // Any return to equality drops the partial count
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_TC) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      if (EDGE_TYPE == 0) begin
         edge_det = deb_q & ~deb_dly_q;
      end else if (EDGE_TYPE == 1) begin
         edge_det = ~deb_q & deb_dly_q;
      end else begin
         edge_det = deb_q ^ deb_dly_q;
      end
   end

   always_comb begin
      irq_mask_d = irq_mask_q;
      clr_mask   = '0;
      if (wr_en && address == 2'd2) begin
         irq_mask_d = writedata[WIDTH-1:0];
      end
      if (wr_en && address == 2'd3) begin
         clr_mask = writedata[WIDTH-1:0];
      end
      // A new edge wins over a simultaneous clear of the same bit
      edge_cap_d = (edge_cap_q & ~clr_mask) | edge_det;
      irq_d      = |(edge_cap_q & irq_mask_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= RESET_VALUE;
         sync2_q    <= RESET_VALUE;
         deb_q      <= RESET_VALUE;
         deb_dly_q  <= RESET_VALUE;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         irq_q      <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         deb_q      <= deb_d;
         deb_dly_q  <= deb_dly_d;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         irq_q      <= irq_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (address)
         2'd0:    rdata[WIDTH-1:0] = deb_q;
         2'd2:    rdata[WIDTH-1:0] = irq_mask_q;
         2'd3:    rdata[WIDTH-1:0] = edge_cap_q;
         default: rdata = '0;
      endcase
   end

   assign readdata = rdata;
   assign irq      = irq_q;

endmodule

// File: tb/tb_soc_pio_button.sv
// Directed bench for soc_pio_button: WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge capture.
// Inputs change 1 ns after each rising edge; checks are taken mid-cycle.
module tb_soc_pio_button;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   soc_pio_button #(
      .WIDTH(4),
      .DEBOUNCE_CYCLES(4),
      .EDGE_TYPE(1),
      .RESET_VALUE(4'hF)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .in_port(in_port),
      .readdata(readdata),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      #1;
      chk(tag, readdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   initial begin
      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'hF;
      tick(3);
      chk_rd("rst_data", 2'd0, 32'h0000_000F);
      chk_rd("rst_cap", 2'd3, 32'h0);
      chk_rd("rst_mask", 2'd2, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);

      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         chk("idle_irq", {31'b0, irq}, 32'h0);
      end
      chk_rd("idle_data", 2'd0, 32'h0000_000F);
      chk_rd("idle_cap", 2'd3, 32'h0);
      chk_rd("rsvd", 2'd1, 32'h0);

      // bit 0 falls: debounced after exactly 6 edges, captured one edge later
      in_port = 4'hE;
      for (int i = 1; i <= 5; i++) begin
         tick(1);
         chk_rd("b0_early", 2'd0, 32'h0000_000F);
      end
      tick(1);
      chk_rd("b0_deb", 2'd0, 32'h0000_000E);
      chk_rd("b0_cap_pre", 2'd3, 32'h0);
      tick(1);
      chk_rd("b0_cap", 2'd3, 32'h1);
      chk("b0_irq", {31'b0, irq}, 32'h0);
      tick(2);
      chk("b0_irq_late", {31'b0, irq}, 32'h0);

      // 3-cycle glitch on bit 2 is rejected
      in_port = 4'hA;
      tick(3);
      in_port = 4'hE;
      tick(10);
      chk_rd("glitch_data", 2'd0, 32'h0000_000E);
      chk_rd("glitch_cap", 2'd3, 32'h1);

      // data register ignores writes
      wr(2'd0, 32'h0);
      chk_rd("data_ro", 2'd0, 32'h0000_000E);

      // mask write with junk upper bits; irq follows one edge later
      wr(2'd2, 32'hFFFF_FFF5);
      chk_rd("mask_rd", 2'd2, 32'h5);
      chk("irq_lag", {31'b0, irq}, 32'h0);
      tick(1);
      chk("irq_set", {31'b0, irq}, 32'h1);

      wr(2'd3, 32'h1);
      chk_rd("cap_clr", 2'd3, 32'h0);
      chk("irq_hold", {31'b0, irq}, 32'h1);
      tick(1);
      chk("irq_clr", {31'b0, irq}, 32'h0);

      // bit 1 falls; clear of bit 1 lands on the same edge as the capture
      in_port = 4'hC;
      tick(6);
      chk_rd("b1_deb", 2'd0, 32'h0000_000C);
      wr(2'd3, 32'h2);
      chk_rd("set_wins", 2'd3, 32'h2);
      tick(1);
      chk("b1_irq_masked", {31'b0, irq}, 32'h0);
      wr(2'd3, 32'h2);
      chk_rd("b1_clr", 2'd3, 32'h0);

      // rising edges are not captured
      in_port = 4'hF;
      tick(8);
      chk_rd("rise_data", 2'd0, 32'h0000_000F);
      chk_rd("rise_cap", 2'd3, 32'h0);

      // reset in the middle of a bit-3 debounce
      in_port = 4'h7;
      tick(4);
      chk_rd("mid_data", 2'd0, 32'h0000_000F);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      chk_rd("mid_rst_data", 2'd0, 32'h0000_000F);
      chk_rd("mid_rst_mask", 2'd2, 32'h0);
      for (int i = 1; i <= 5; i++) begin
         tick(1);
         chk_rd("b3_early", 2'd0, 32'h0000_000F);
      end
      tick(1);
      chk_rd("b3_deb", 2'd0, 32'h0000_0007);
      tick(1);
      chk_rd("b3_cap", 2'd3, 32'h8);
      chk("b3_irq", {31'b0, irq}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
